// File: rtl/merged_pe2_pkg.sv
// merged_pe2_pkg: shared LLR widths, types and sign-magnitude helpers for the merged PE.
package merged_pe2_pkg;
    localparam int LLR_W = 9;
    localparam int MAG_W = LLR_W - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};
    typedef logic [LLR_W-1:0] llr_t;
    function automatic llr_t sm_neg(input llr_t v);
        return (v[MAG_W-1:0] == '0) ? '0 : {~v[MAG_W], v[MAG_W-1:0]};
    endfunction
endpackage

// File: rtl/llr_sm_addsub.sv
// llr_sm_addsub: combinational sign-magnitude y = b + a (sub=0) or b - a (sub=1).
// MERGED_PE2_SAT_EN selects magnitude saturation; otherwise the carry is dropped.
module llr_sm_addsub
    import merged_pe2_pkg::*;
(
    input  logic [LLR_W-1:0] a,
    input  logic [LLR_W-1:0] b,
    input  logic             sub,
    output logic [LLR_W-1:0] y
);
    llr_t ae;
    logic signed [MAG_W+1:0] va, vb, s;
    logic [MAG_W+1:0] abs_v;
    logic [MAG_W-1:0] mo;
    always_comb begin
        ae = sub ? sm_neg(a) : a;
        va = ae[MAG_W] ? -{2'b00, ae[MAG_W-1:0]} : {2'b00, ae[MAG_W-1:0]};
        vb = b[MAG_W] ? -{2'b00, b[MAG_W-1:0]} : {2'b00, b[MAG_W-1:0]};
        s = va + vb;
        abs_v = s[MAG_W+1] ? -s : s;
`ifdef MERGED_PE2_SAT_EN
        mo = abs_v[MAG_W] ? MAG_MAX : abs_v[MAG_W-1:0];
`else
        mo = abs_v[MAG_W-1:0];
`endif
        // a zero magnitude never carries a sign, which also covers the wrapped case
        y = {s[MAG_W+1] & |mo, mo};
    end
endmodule

// File: rtl/merged_pe2.sv
// merged_pe2: one-cycle f plus both g candidates (u=0/u=1) for an SC polar decoder.
// MERGED_PE2_SAT_EN (in llr_sm_addsub) saturates g overflow instead of wrapping.
module merged_pe2
    import merged_pe2_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [LLR_W-1:0] merge_in1,
    input  logic [LLR_W-1:0] merge_in2,
    output logic             out_valid,
    output logic [LLR_W-1:0] merge_out1,
    output logic [LLR_W-1:0] merge_out2,
    output logic [LLR_W-1:0] merge_out3
);
    logic [MAG_W-1:0] mn;
    llr_t f, g0, g1;
    always_comb begin
        mn = (merge_in1[MAG_W-1:0] < merge_in2[MAG_W-1:0]) ? merge_in1[MAG_W-1:0] : merge_in2[MAG_W-1:0];
        f = {(merge_in1[MAG_W] ^ merge_in2[MAG_W]) & |mn, mn};
    end
    llr_sm_addsub u_g0 (.a(merge_in1), .b(merge_in2), .sub(1'b0), .y(g0));
    llr_sm_addsub u_g1 (.a(merge_in1), .b(merge_in2), .sub(1'b1), .y(g1));
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            merge_out1 <= '0;
            merge_out2 <= '0;
            merge_out3 <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                merge_out1 <= f;
                merge_out2 <= g0;
                merge_out3 <= g1;
            end
        end
    end
endmodule

// File: tb/tb_merged_pe2.sv
// tb_merged_pe2: directed vectors with hand-computed results for merged_pe2.
module tb_merged_pe2;
    logic clk = 1'b0;
    logic rst, in_valid, out_valid;
    logic [8:0] merge_in1, merge_in2, merge_out1, merge_out2, merge_out3;
    int n_assert = 0;
    int n_fail = 0;

    merged_pe2 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .merge_in1(merge_in1), .merge_in2(merge_in2),
        .out_valid(out_valid), .merge_out1(merge_out1),
        .merge_out2(merge_out2), .merge_out3(merge_out3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [8:0] a, input logic [8:0] b);
        @(negedge clk);
        rst = r;
        in_valid = v;
        merge_in1 = a;
        merge_in2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string tag, input logic ev, input logic [8:0] e1,
                           input logic [8:0] e2, input logic [8:0] e3);
        check({tag, "_valid"}, {8'd0, out_valid}, {8'd0, ev});
        check({tag, "_out1"}, merge_out1, e1);
        check({tag, "_out2"}, merge_out2, e2);
        check({tag, "_out3"}, merge_out3, e3);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        merge_in1 = '0;
        merge_in2 = '0;
        step(1'b1, 1'b0, 9'h000, 9'h000);
        step(1'b0, 1'b1, 9'h08C, 9'h151);
        expect4("nominal", 1'b1, 9'h151, 9'h03B, 9'h1DD);
`ifdef MERGED_PE2_SAT_EN
        step(1'b0, 1'b1, 9'h0C8, 9'h064);
        expect4("overflow", 1'b1, 9'h064, 9'h0FF, 9'h164);
        step(1'b0, 1'b1, 9'h1FF, 9'h1FF);
        expect4("neg_max", 1'b1, 9'h0FF, 9'h1FF, 9'h000);
        step(1'b0, 1'b1, 9'h080, 9'h180);
        expect4("wrap_zero", 1'b1, 9'h180, 9'h000, 9'h1FF);
`else
        step(1'b0, 1'b1, 9'h0C8, 9'h064);
        expect4("overflow", 1'b1, 9'h064, 9'h02C, 9'h164);
        step(1'b0, 1'b1, 9'h1FF, 9'h1FF);
        expect4("neg_max", 1'b1, 9'h0FF, 9'h1FE, 9'h000);
        step(1'b0, 1'b1, 9'h080, 9'h180);
        expect4("wrap_zero", 1'b1, 9'h180, 9'h000, 9'h000);
`endif
        step(1'b0, 1'b1, 9'h132, 9'h032);
        expect4("zero_res", 1'b1, 9'h132, 9'h000, 9'h064);
        step(1'b0, 1'b1, 9'h100, 9'h105);
        expect4("neg_zero", 1'b1, 9'h000, 9'h105, 9'h105);
        step(1'b0, 1'b1, 9'h000, 9'h100);
        expect4("both_zero", 1'b1, 9'h000, 9'h000, 9'h000);
        step(1'b0, 1'b1, 9'h005, 9'h003);
        expect4("tog1", 1'b1, 9'h003, 9'h008, 9'h102);
        step(1'b0, 1'b0, 9'h0C8, 9'h064);
        expect4("tog0_hold", 1'b0, 9'h003, 9'h008, 9'h102);
        step(1'b0, 1'b1, 9'h10A, 9'h014);
        expect4("tog1_again", 1'b1, 9'h10A, 9'h00A, 9'h01E);
        step(1'b1, 1'b1, 9'h08C, 9'h151);
        expect4("rst_prio", 1'b0, 9'h000, 9'h000, 9'h000);
        step(1'b0, 1'b0, 9'h000, 9'h000);
        expect4("post_rst_idle", 1'b0, 9'h000, 9'h000, 9'h000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
